// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU arbiter.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOTA = 3'b101;
  localparam logic [2:0] ALU_NAND = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrate, register operands,
// capture the result one cycle later and hold it on the owner's response channel.
//
// state   | meaning
// IDLE    | waiting for a request; grant is offered combinationally
// EXEC    | ALU settling from registered operands; result captured at the edge
// RESP    | result presented to the owner until it takes it
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic               rsp0_valid_q, rsp0_valid_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic               busy_q, busy_d;
  logic [1:0]         grant;
  logic               owner_rsp_ready;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Ready is gated by rst_n so a held reset never advertises acceptance.
  assign req0_ready = rst_n && (state_q == ST_IDLE) && grant[0];
  assign req1_ready = rst_n && (state_q == ST_IDLE) && grant[1];

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    result_d     = result_q;
    zero_d       = zero_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d   = ST_EXEC;
          busy_d    = 1'b1;
          owner_d   = grant[1];
          alu_a_d   = grant[1] ? req1_a   : req0_a;
          alu_b_d   = grant[1] ? req1_b   : req0_b;
          alu_sel_d = grant[1] ? req1_sel : req0_sel;
        end
      end
      ST_EXEC: begin
        state_d      = ST_RESP;
        result_d     = alu_out;
        zero_d       = (alu_out == '0);
        rsp0_valid_d = !owner_q;
        rsp1_valid_d = owner_q;
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          last_grant_d = owner_q;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        busy_d       = 1'b0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign busy       = busy_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_valid_q ? result_q : '0;
  assign rsp1_data  = rsp1_valid_q ? result_q : '0;
  assign rsp0_zero  = rsp0_valid_q & zero_q;
  assign rsp1_zero  = rsp1_valid_q & zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, plus literal result pins.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
  logic [2:0] req0_sel, req1_sel, alu_sel;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [2:0] s);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return ~(a & b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_sel);

  alu_arbiter #(.WIDTH(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .busy(busy)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: at most one operation outstanding, aged in cycles since accept.
  bit         m_busy = 0;
  int         m_age = 0;
  int         m_owner = 0;
  int         m_last = 1;
  logic [7:0] m_res = 0;
  logic [7:0] m_a = 0, m_b = 0;
  logic [2:0] m_sel = 0;

  int         q_own[$];
  logic [7:0] q_data[$];
  logic       q_zero[$];

  always @(negedge clk) begin
    bit         ev0, ev1, e_rv0, e_rv1, e_r0, e_r1;
    logic [7:0] ed0, ed1;
    if (!rst_n) begin
      m_busy = 0; m_last = 1; m_a = 0; m_b = 0; m_sel = 0;
      chk("reset_ctrl", {busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp1_zero, rsp0_zero}, 0);
      chk("reset_data", {rsp1_data, rsp0_data}, 0);
      chk("reset_alu", {alu_a, alu_b, alu_sel}, 0);
    end else begin
      ev0 = req0_valid; ev1 = req1_valid;
      e_rv0 = m_busy && m_age >= 2 && m_owner == 0;
      e_rv1 = m_busy && m_age >= 2 && m_owner == 1;
      e_r0 = !m_busy && ev0 && !(ev1 && m_last == 0);
      e_r1 = !m_busy && ev1 && !(ev0 && m_last == 1);
      ed0 = e_rv0 ? m_res : 8'h00;
      ed1 = e_rv1 ? m_res : 8'h00;
      chk("model_ctrl", {busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp1_zero, rsp0_zero},
          {m_busy, e_r1, e_r0, e_rv1, e_rv0, e_rv1 && ed1 == 0, e_rv0 && ed0 == 0});
      chk("model_data", {rsp1_data, rsp0_data}, {ed1, ed0});
      chk("model_alu", {alu_a, alu_b, alu_sel}, {m_a, m_b, m_sel});
      if (rsp0_valid && rsp0_ready) begin q_own.push_back(0); q_data.push_back(rsp0_data); q_zero.push_back(rsp0_zero); end
      if (rsp1_valid && rsp1_ready) begin q_own.push_back(1); q_data.push_back(rsp1_data); q_zero.push_back(rsp1_zero); end
      if (!m_busy) begin
        if (e_r0 || e_r1) begin
          m_owner = e_r1 ? 1 : 0;
          m_a   = e_r1 ? req1_a : req0_a;
          m_b   = e_r1 ? req1_b : req0_b;
          m_sel = e_r1 ? req1_sel : req0_sel;
          m_res = alu_ref(m_a, m_b, m_sel);
          m_busy = 1; m_age = 1;
        end
      end else if (m_age >= 2 && (m_owner == 1 ? rsp1_ready : rsp0_ready)) begin
        m_busy = 0; m_last = m_owner;
      end else begin
        m_age++;
      end
    end
  end

  // Advance n cycles, dropping each valid right after its handshake edge.
  task automatic run_cycles(int n);
    bit hs0, hs1;
    repeat (n) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (hs0) req0_valid = 0;
      if (hs1) req1_valid = 0;
    end
  endtask

  task automatic pop_chk(string nm, int eo, logic [7:0] ed, logic ez);
    chk({nm, "_present"}, q_own.size() != 0, 1);
    if (q_own.size() != 0) begin
      chk({nm, "_owner"}, q_own.pop_front(), eo);
      chk({nm, "_data"}, q_data.pop_front(), ed);
      chk({nm, "_zero"}, q_zero.pop_front(), ez);
    end
  endtask

  task automatic set_req(int n, logic [7:0] a, logic [7:0] b, logic [2:0] s);
    if (n == 0) begin req0_a = a; req0_b = b; req0_sel = s; req0_valid = 1; end
    else begin req1_a = a; req1_b = b; req1_sel = s; req1_valid = 1; end
  endtask

  logic [7:0] zt_a [3] = '{8'h05, 8'hFF, 8'h05};
  logic [7:0] zt_b [3] = '{8'h05, 8'h01, 8'h00};
  logic [2:0] zt_s [3] = '{ALU_SUB, ALU_ADD, ALU_NOTA};
  logic [7:0] zt_d [3] = '{8'h00, 8'h00, 8'hFA};
  logic       zt_z [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;

    // Reset held with random request activity.
    repeat (3) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sel = 3'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sel = 3'($urandom);
    end
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rst_n = 1;
    run_cycles(3);
    chk("idle_after_release", busy, 0);

    // Single op: 5 + 3.
    set_req(0, 8'h05, 8'h03, ALU_ADD);
    run_cycles(1);
    @(negedge clk);
    chk("exec_sel", alu_sel, ALU_ADD);
    chk("exec_busy", busy, 1);
    chk("exec_no_rsp", {rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);
    chk("t2_rsp0_valid", rsp0_valid, 1);
    chk("t2_rsp1_valid", rsp1_valid, 0);
    run_cycles(3);
    pop_chk("single", 0, 8'h08, 0);

    // Contention after a fresh reset: req0 first, then req1; then req0 again.
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    set_req(0, 8'h05, 8'h03, ALU_SUB);
    set_req(1, 8'h05, 8'h03, ALU_XOR);
    run_cycles(10);
    pop_chk("cont_first", 0, 8'h02, 0);
    pop_chk("cont_second", 1, 8'h06, 0);
    set_req(0, 8'h0F, 8'h3C, ALU_AND);
    set_req(1, 8'h0F, 8'h3C, ALU_OR);
    run_cycles(10);
    pop_chk("alt_first", 0, 8'h0C, 0);
    pop_chk("alt_second", 1, 8'h3F, 0);

    // Backpressure on rsp0 while req1 waits.
    rsp0_ready = 0;
    set_req(0, 8'h0F, 8'hF0, ALU_XOR);
    run_cycles(1);
    set_req(1, 8'h10, 8'h01, ALU_SUB);
    run_cycles(1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp0_valid, 1);
      chk("bp_data", {rsp0_zero, rsp0_data}, {1'b0, 8'hFF});
      chk("bp_hold", {busy, req1_ready}, 2'b10);
    end
    @(posedge clk); #1 rsp0_ready = 1;
    run_cycles(8);
    pop_chk("bp_rsp0", 0, 8'hFF, 0);
    pop_chk("bp_rsp1", 1, 8'h0F, 0);

    // Zero flag and wrap-around.
    for (int i = 0; i < 3; i++) begin
      set_req(1, zt_a[i], zt_b[i], zt_s[i]);
      run_cycles(5);
      pop_chk($sformatf("zero_wrap%0d", i), 1, zt_d[i], zt_z[i]);
    end

    // Reset during EXEC: no response, and grant order restarts at req0.
    set_req(0, 8'hFF, 8'h0F, ALU_AND);
    run_cycles(5);
    pop_chk("pre_reset", 0, 8'h0F, 0);
    set_req(0, 8'h01, 8'h01, ALU_ADD);
    run_cycles(1);
    rst_n = 0;
    run_cycles(2);
    rst_n = 1;
    run_cycles(6);
    chk("no_rsp_after_reset", q_own.size(), 0);
    set_req(0, 8'h0F, 8'h0F, ALU_NAND);
    set_req(1, 8'h01, 8'h02, ALU_ADD);
    run_cycles(10);
    pop_chk("post_reset_first", 0, 8'hF0, 0);
    pop_chk("post_reset_second", 1, 8'h03, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared combinational 8-bit ALU (operands a/b, 3-bit sel, result out). It accepts operation requests over valid/ready channels and drives the ALU from registered operands. It captures the result and returns it, with a zero flag, on a per-requester response channel. It sits between the ALU instance and its clients, so one ALU serves two initiators without contention.

Parameters:
WIDTH, 8, operand/result width; must match the ALU instance.
SEL_W, 3, opcode width; must match the ALU sel port.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req0_sel  in  SEL_W  requester 0 opcode
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes result
rsp0_data  out  WIDTH  result for requester 0
rsp0_zero  out  1  high when rsp0_data == 0
req1_*, rsp1_*  same set, same widths, same meaning, for requester 1
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_sel  out  SEL_W  to ALU sel
alu_out  in  WIDTH  from ALU out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; alu_a/alu_b/alu_sel=0; result reg=0; all rsp*_valid, rsp*_data, rsp*_zero, req*_ready and busy=0; last_grant=1, so req0 wins the first contention.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - grant = rr(req0_valid, req1_valid, last_grant). With a single valid, that requester is granted. With both valid, the requester that is not last_grant is granted.
  - reqN_ready = (state==IDLE) && grantN. This is combinational from valid. Requesters must not make valid depend on ready.
  - On a handshake, latch a/b/sel into alu_a/alu_b/alu_sel regs, latch owner, and go to EXEC.
- EXEC (exactly 1 cycle): the ALU settles from the registered inputs. At the clock edge, result <= alu_out, zero <= (alu_out==0), and the FSM goes to RESP.
- RESP:
  - rsp<owner>_valid=1; rsp_data and rsp_zero come from registers. The other requester's response outputs stay 0.
  - Hold until rsp<owner>_ready=1. Then go to IDLE and set last_grant<=owner.
  - Data and zero are stable while valid && !ready.
- Latency: handshake at edge T, rsp_valid high from T+2. Minimum spacing between accepts is 3 cycles. A new request is never accepted in the same cycle as a response handshake.
- alu_a/alu_b/alu_sel hold their last values in IDLE and RESP. They change only on an accept.
- Results pass through unmodified. Width and overflow behaviour (mod 2^WIDTH) is the ALU's; the arbiter neither checks nor alters opcodes.
- Backpressure: while in RESP, both req*_ready stay 0 regardless of valid.
- A requester must hold valid and its operands stable until ready. Withdrawal before ready is not supported and not detected.
- Reset mid-operation: an in-flight transaction is dropped with no response. last_grant returns to 1.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_NOTA=101, ALU_NAND=110;
  - state encoding ST_IDLE/ST_EXEC/ST_RESP.
- One sub-module: rr_arb2. It is a combinational 2-way round-robin grant from (valid[1:0], last_grant) to a one-hot grant.
- The ALU itself is instantiated outside this block.

Test Plan:
- Reset: hold rst_n=0 with random request inputs -> all outputs 0 and busy=0. Release with no valid -> stays IDLE.
- Single op: req0 a=0x05 b=0x03 sel=000, accepted at T -> alu_sel=000 during EXEC; rsp0_valid at T+2 with data=0x08, zero=0; rsp1_valid stays 0.
- Contention: both valid after reset, req0 sel=001 and req1 sel=100, a=0x05 b=0x03 -> req0 served first (0x02), then req1 (0x06). Both valid again -> req0 granted (alternation).
- Backpressure: rsp0_ready=0 for 5 cycles with req1_valid=1 -> rsp0_valid, data and zero stable; req1_ready=0 and busy=1 throughout; req1 accepted the cycle after IDLE is re-entered.
- Zero/wrap: a=0x05 b=0x05 sel=001 -> data=0x00, zero=1. a=0xFF b=0x01 sel=000 -> data=0x00, zero=1. a=0x05 sel=101 -> data=0xFA, zero=0.
- Reset mid-op: drop rst_n during EXEC -> no response ever issued; next contention grants req0.
